mem_arbiter: RTL and testbench
==============================

# mem_arbiter

- Sits directly below the `cpu` core and merges its two memory ports (`imem_*` fetch, `dmem_*` load/store) onto one unified memory port.
- Serves one transaction at a time and latches the granted request so the memory side sees stable values.
- Returns data and a single-cycle `*_resp` pulse to the requesting port.
- The core holds each request stable until it sees its `*_resp`; the arbiter relies on that behaviour.

## Interface
Parameters:
- `STARVE_MAX`, default 4: consecutive dmem grants allowed while imem waits, fixed-priority mode only (range 1–15).

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_addr` in 32: fetch address.
- `imem_rmask` in 4: fetch request when nonzero.
- `imem_rdata` out 32: fetch data, valid with `imem_resp`.
- `imem_resp` out 1: one-cycle fetch completion.
- `dmem_addr` in 32: load/store address.
- `dmem_rmask` in 4: load byte mask.
- `dmem_wmask` in 4: store byte mask.
- `dmem_wdata` in 32: store data.
- `dmem_rdata` out 32: load data, valid with `dmem_resp`.
- `dmem_resp` out 1: one-cycle load/store completion.
- `mem_addr` out 32: word-aligned address to memory.
- `mem_read` out 1: read strobe, held until `mem_resp`.
- `mem_write` out 1: write strobe, held until `mem_resp`.
- `mem_wmask` out 4: write byte mask.
- `mem_wdata` out 32: write data.
- `mem_rdata` in 32: read data, valid with `mem_resp`.
- `mem_resp` in 1: memory completion, one cycle.

## Operation
- Request detection:
  - imem_req = |imem_rmask.
  - dmem_req = |dmem_rmask | |dmem_wmask.
  - If `dmem_rmask` and `dmem_wmask` are both nonzero, the write wins: `mem_write` is issued and the rmask is ignored.
- States:
  - IDLE: no transaction.
  - BUSY_I: imem transaction outstanding.
  - BUSY_D: dmem transaction outstanding.
  - RESP: response cycle; requests are ignored.
- IDLE:
  - Evaluate the arbitration rule and latch `{addr[31:2],2'b00}`, masks and wdata of the winner into the `mem_*` output registers.
  - Go to BUSY_I or BUSY_D. With no request, stay in IDLE.
- BUSY_x:
  - Hold the `mem_*` outputs constant.
  - On `mem_resp`, register `mem_rdata` into the winner's `*_rdata` register, set `*_resp` for the next cycle, drop `mem_read` and `mem_write`, and go to RESP.
- RESP:
  - `*_resp` is high for exactly this cycle.
  - CPU request inputs are ignored in this cycle, because they still show the just-completed request.
  - Go to IDLE.
- Arbitration, fixed priority (default):
  - dmem wins over imem.
  - A 4-bit `starve_cnt` increments on each dmem grant while imem_req is high, and clears on any imem grant.
  - When `starve_cnt == STARVE_MAX`, imem wins the next simultaneous request.
- `*_rdata` holds its last value until overwritten; it is meaningful only while `*_resp` is high.
- For writes, `dmem_rdata` is left unchanged; only `dmem_resp` pulses.
- Reset values: every output is 0, state = IDLE, `starve_cnt` = 0.
- Reset mid-transaction: the outstanding transaction is abandoned with no `*_resp`. The memory model is reset by the same `rst_n`.

## Timing
- Request first visible in IDLE at cycle N → `mem_read`/`mem_write` high in cycle N+1.
- `mem_resp` at cycle M → `*_resp` and `*_rdata` valid in cycle M+1 (RESP) → IDLE in M+2.
- Best case (`mem_resp` in N+1): `*_resp` at N+2. Back-to-back transactions therefore complete every 3 cycles minimum.
- A request arriving while the arbiter is in BUSY_x or RESP waits; it is evaluated at the next IDLE cycle.
- `mem_resp` outside BUSY_x is ignored.
- At most one `*_resp` is high per cycle; both are never high together.
- No combinational path from any input to any output.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Round-robin arbitration. A 1-bit `last_grant` register records the last winner.
  - On simultaneous requests, the port not granted last wins. `last_grant` resets to dmem, so imem wins the first tie.
  - `STARVE_MAX` and `starve_cnt` are unused and removed.
- Undefined: fixed dmem priority with the starvation counter, as in Operation.

## Test plan
- Single fetch: imem_addr=0x6000_0006, rmask=0xF; memory responds after 3 cycles with 0x0000_0013 → mem_addr=0x6000_0004, mem_read held 3 cycles, imem_resp for 1 cycle with imem_rdata=0x0000_0013.
- Store: dmem_addr=0x1000, wmask=0x3, wdata=0xABCD → mem_write=1, mem_wmask=0x3, mem_wdata=0xABCD; dmem_resp pulses once; dmem_rdata unchanged.
- Simultaneous imem+dmem in IDLE, default build → dmem served first; imem served next. With `MEM_ARB_RR_EN`, imem first.
- Starvation, STARVE_MAX=2: imem held, dmem re-requests 3 times → grant order D, D, I, D.
- Stale request: the core keeps the request high through the RESP cycle → exactly one `mem_read` and one `*_resp`; no duplicate transaction.
- `rst_n` low during BUSY_D with a read outstanding → all outputs 0 immediately; no `dmem_resp`; after release, a new imem request is served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter: merges the core's fetch port (imem_*) and load/store port
// (dmem_*) onto one memory port, one transaction at a time.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   imem_addr/rmask            fetch request (request when rmask != 0)
//   imem_rdata/resp            fetch data, one-cycle completion pulse
//   dmem_addr/rmask/wmask/wdata load/store request (store wins if both masks set)
//   dmem_rdata/resp            load data (unchanged by stores), completion pulse
//   mem_addr/read/write/wmask/wdata  registered memory request, held until mem_resp
//   mem_rdata/resp             memory read data and one-cycle completion
//
// Parameter
//   STARVE_MAX  consecutive dmem grants allowed while imem waits (1..15),
//               fixed-priority build only.
//
// Build option
//   MEM_ARB_RR_EN  round-robin arbitration on ties instead of dmem priority
//                  with a starvation counter.
//
// All outputs come straight from flops; there is no input-to-output
// combinational path.

module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [3:0]  mem_wmask_q, mem_wmask_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] imem_rdata_q, imem_rdata_d;
    logic        imem_resp_q, imem_resp_d;
    logic [31:0] dmem_rdata_q, dmem_rdata_d;
    logic        dmem_resp_q, dmem_resp_d;

`ifdef MEM_ARB_RR_EN
    // 1: imem won last, 0: dmem won last (reset value, so imem wins first tie)
    logic        last_grant_q, last_grant_d;
`else
    logic [3:0]  starve_cnt_q, starve_cnt_d;
`endif

    logic imem_req, dmem_req, dmem_is_wr;
    logic grant_i, grant_d;

    assign imem_req   = |imem_rmask;
    assign dmem_req   = (|dmem_rmask) | (|dmem_wmask);
    assign dmem_is_wr = |dmem_wmask;

`ifdef MEM_ARB_RR_EN
    assign grant_i = imem_req && (!dmem_req || !last_grant_q);
`else
    // Counter never passes STARVE_MAX: once equal, a waiting imem wins and clears it.
    assign grant_i = imem_req && (!dmem_req || starve_cnt_q == 4'(STARVE_MAX));
`endif
    assign grant_d = dmem_req && !grant_i;

    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_wmask_d  = mem_wmask_q;
        mem_wdata_d  = mem_wdata_q;
        imem_rdata_d = imem_rdata_q;
        dmem_rdata_d = dmem_rdata_q;
        imem_resp_d  = 1'b0;
        dmem_resp_d  = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_grant_d = last_grant_q;
`else
        starve_cnt_d = starve_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    mem_addr_d  = {imem_addr[31:2], 2'b00};
                    mem_read_d  = 1'b1;
                    mem_write_d = 1'b0;
                    mem_wmask_d = 4'h0;
                    mem_wdata_d = 32'h0;
                    state_d     = BUSY_I;
`ifdef MEM_ARB_RR_EN
                    last_grant_d = 1'b1;
`else
                    starve_cnt_d = 4'd0;
`endif
                end else if (grant_d) begin
                    mem_addr_d  = {dmem_addr[31:2], 2'b00};
                    mem_read_d  = !dmem_is_wr;
                    mem_write_d = dmem_is_wr;
                    mem_wmask_d = dmem_wmask;
                    mem_wdata_d = dmem_wdata;
                    state_d     = BUSY_D;
`ifdef MEM_ARB_RR_EN
                    last_grant_d = 1'b0;
`else
                    if (imem_req) starve_cnt_d = starve_cnt_q + 4'd1;
`endif
                end
            end
            BUSY_I: begin
                if (mem_resp) begin
                    imem_rdata_d = mem_rdata;
                    imem_resp_d  = 1'b1;
                    mem_read_d   = 1'b0;
                    mem_write_d  = 1'b0;
                    state_d      = RESP;
                end
            end
            BUSY_D: begin
                if (mem_resp) begin
                    // stores leave the load data register untouched
                    if (!mem_write_q) dmem_rdata_d = mem_rdata;
                    dmem_resp_d = 1'b1;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = RESP;
                end
            end
            // Core inputs still show the finished request here; ignore them.
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mem_addr_q   <= 32'h0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_wmask_q  <= 4'h0;
            mem_wdata_q  <= 32'h0;
            imem_rdata_q <= 32'h0;
            imem_resp_q  <= 1'b0;
            dmem_rdata_q <= 32'h0;
            dmem_resp_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= 1'b0;
`else
            starve_cnt_q <= 4'd0;
`endif
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_wmask_q  <= mem_wmask_d;
            mem_wdata_q  <= mem_wdata_d;
            imem_rdata_q <= imem_rdata_d;
            imem_resp_q  <= imem_resp_d;
            dmem_rdata_q <= dmem_rdata_d;
            dmem_resp_q  <= dmem_resp_d;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= last_grant_d;
`else
            starve_cnt_q <= starve_cnt_d;
`endif
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_wmask  = mem_wmask_q;
    assign mem_wdata  = mem_wdata_q;
    assign imem_rdata = imem_rdata_q;
    assign imem_resp  = imem_resp_q;
    assign dmem_rdata = dmem_rdata_q;
    assign dmem_resp  = dmem_resp_q;

    // Byte-offset bits are dropped on purpose (memory is word addressed).
    logic unused_bits;
`ifdef MEM_ARB_RR_EN
    assign unused_bits = ^{imem_addr[1:0], dmem_addr[1:0], 4'(STARVE_MAX)};
`else
    assign unused_bits = ^{imem_addr[1:0], dmem_addr[1:0]};
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_arbiter: behavioural memory with programmable latency,
// scoreboard queues for memory-side requests and core-side responses.

module tb_mem_arbiter;

    localparam int unsigned STARVE = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr = '0;
    logic [3:0]  imem_rmask = '0;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] dmem_addr = '0;
    logic [3:0]  dmem_rmask = '0;
    logic [3:0]  dmem_wmask = '0;
    logic [31:0] dmem_wdata = '0;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_resp = 1'b0;

    mem_arbiter #(.STARVE_MAX(STARVE)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_rmask(imem_rmask),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        bit          wr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } mtx_t;

    rsp_t exp_rsp[$];
    mtx_t exp_mem[$];
    rsp_t er;
    mtx_t em;

    int n_chk = 0;
    int n_err = 0;
    int mem_lat = 1;
    int mcnt = 0;
    int n_txn = 0;
    int n_iresp = 0;
    int n_dresp = 0;
    logic [31:0] d_rdata_exp = '0;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a == 32'h6000_0004) ? 32'h0000_0013 : ((a ^ 32'hC0DE_0000) + 32'd1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory model: answers after mem_lat cycles of an active strobe.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_resp = 1'b0;
            mcnt = 0;
        end else if (mem_resp) begin
            mem_resp = 1'b0;
        end else if (mem_read || mem_write) begin
            mcnt++;
            if (mcnt >= mem_lat) begin
                mcnt = 0;
                mem_resp = 1'b1;
                mem_rdata = mdata(mem_addr);
                n_txn++;
                if (exp_mem.size() == 0) begin
                    check("mem_unexp", 32'd1, 32'd0);
                end else begin
                    em = exp_mem.pop_front();
                    check("mem_addr", mem_addr, em.addr);
                    check("mem_write", 32'(mem_write), 32'(em.wr));
                    check("mem_read", 32'(mem_read), 32'(!em.wr));
                    check("mem_wmask", 32'(mem_wmask), 32'(em.wmask));
                    if (em.wr) check("mem_wdata", mem_wdata, em.wdata);
                end
            end
        end
    end

    // Response monitor: every *_resp pulse pops one expected response.
    always @(negedge clk) begin
        if (rst_n && (imem_resp || dmem_resp)) begin
            check("resp_excl", 32'(imem_resp & dmem_resp), 32'd0);
            if (imem_resp) n_iresp++;
            if (dmem_resp) n_dresp++;
            if (exp_rsp.size() == 0) begin
                check("rsp_unexp", 32'd1, 32'd0);
            end else begin
                er = exp_rsp.pop_front();
                check("rsp_port", 32'(dmem_resp), 32'(er.is_d));
                check("rsp_data", dmem_resp ? dmem_rdata : imem_rdata, er.data);
            end
        end
    end

    task automatic exp_i(input logic [31:0] a);
        mtx_t m;
        rsp_t r;
        m.addr = {a[31:2], 2'b00}; m.wr = 1'b0; m.wmask = 4'h0; m.wdata = 32'h0;
        r.is_d = 1'b0; r.data = mdata(m.addr);
        exp_mem.push_back(m);
        exp_rsp.push_back(r);
    endtask

    task automatic exp_dr(input logic [31:0] a);
        mtx_t m;
        rsp_t r;
        m.addr = {a[31:2], 2'b00}; m.wr = 1'b0; m.wmask = 4'h0; m.wdata = 32'h0;
        d_rdata_exp = mdata(m.addr);
        r.is_d = 1'b1; r.data = d_rdata_exp;
        exp_mem.push_back(m);
        exp_rsp.push_back(r);
    endtask

    task automatic exp_dw(input logic [31:0] a, input logic [3:0] wm, input logic [31:0] wd);
        mtx_t m;
        rsp_t r;
        m.addr = {a[31:2], 2'b00}; m.wr = 1'b1; m.wmask = wm; m.wdata = wd;
        r.is_d = 1'b1; r.data = d_rdata_exp;
        exp_mem.push_back(m);
        exp_rsp.push_back(r);
    endtask

    task automatic wait_resp(input bit is_d);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            #1;
            if (is_d ? dmem_resp : imem_resp) ok = 1'b1;
        end
        if (!ok) check(is_d ? "timeout_dresp" : "timeout_iresp", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

    initial begin
        int rd_cycles;
        int t0;
        int i0;
        int d0;
        bit done;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_resp", 32'({imem_resp, dmem_resp}), 32'd0);
        check("rst_outs", 32'(|{mem_addr, mem_wmask, mem_wdata, imem_rdata, dmem_rdata}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // single fetch, memory latency 3
        mem_lat = 3;
        exp_i(32'h6000_0006);
        imem_addr = 32'h6000_0006; imem_rmask = 4'hF;
        @(negedge clk);
        check("fetch_lat", 32'(mem_read), 32'd1);
        check("fetch_addr", mem_addr, 32'h6000_0004);
        rd_cycles = 1;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (imem_resp) done = 1'b1;
            else if (mem_read) rd_cycles++;
        end
        check("fetch_done", 32'(done), 32'd1);
        check("fetch_rd_cycles", 32'(rd_cycles), 32'd3);
        imem_rmask = 4'h0;
        @(negedge clk);
        check("fetch_pulse", 32'(imem_resp), 32'd0);

        // load, then store, then store with both masks set
        mem_lat = 2;
        exp_dr(32'h0000_2001);
        dmem_addr = 32'h0000_2001; dmem_rmask = 4'h2;
        wait_resp(1'b1);
        dmem_rmask = 4'h0;
        @(negedge clk);

        exp_dw(32'h0000_1000, 4'h3, 32'h0000_ABCD);
        dmem_addr = 32'h0000_1000; dmem_wmask = 4'h3; dmem_wdata = 32'h0000_ABCD;
        wait_resp(1'b1);
        dmem_wmask = 4'h0;
        @(negedge clk);
        check("st_rdata_keep", dmem_rdata, d_rdata_exp);
        check("st_pulse", 32'(dmem_resp), 32'd0);

        exp_dw(32'h0000_3000, 4'hC, 32'h1234_5678);
        dmem_addr = 32'h0000_3000; dmem_rmask = 4'hF; dmem_wmask = 4'hC; dmem_wdata = 32'h1234_5678;
        wait_resp(1'b1);
        dmem_rmask = 4'h0; dmem_wmask = 4'h0;
        @(negedge clk);

        // simultaneous requests
        mem_lat = 1;
`ifdef MEM_ARB_RR_EN
        exp_i(32'h0000_0100);
        exp_dr(32'h0000_4000);
`else
        exp_dr(32'h0000_4000);
        exp_i(32'h0000_0100);
`endif
        imem_addr = 32'h0000_0100; imem_rmask = 4'hF;
        dmem_addr = 32'h0000_4000; dmem_rmask = 4'hF;
`ifdef MEM_ARB_RR_EN
        wait_resp(1'b0);
        imem_rmask = 4'h0;
        wait_resp(1'b1);
        dmem_rmask = 4'h0;
`else
        wait_resp(1'b1);
        dmem_rmask = 4'h0;
        wait_resp(1'b0);
        imem_rmask = 4'h0;
`endif
        @(negedge clk);

`ifndef MEM_ARB_RR_EN
        // starvation: imem held, dmem re-requests -> D, D, I, D
        exp_dr(32'h0000_5000);
        exp_dr(32'h0000_5004);
        exp_i(32'h0000_0200);
        exp_dr(32'h0000_5008);
        imem_addr = 32'h0000_0200; imem_rmask = 4'hF;
        dmem_addr = 32'h0000_5000; dmem_rmask = 4'hF;
        wait_resp(1'b1);
        dmem_addr = 32'h0000_5004;
        wait_resp(1'b1);
        dmem_addr = 32'h0000_5008;
        wait_resp(1'b0);
        imem_rmask = 4'h0;
        wait_resp(1'b1);
        dmem_rmask = 4'h0;
        @(negedge clk);
`endif

        // stale request held through the response cycle
        t0 = n_txn; i0 = n_iresp;
        exp_i(32'h0000_0300);
        imem_addr = 32'h0000_0300; imem_rmask = 4'hF;
        wait_resp(1'b0);
        @(negedge clk);
        imem_rmask = 4'h0;
        repeat (4) @(negedge clk);
        check("stale_txn", 32'(n_txn - t0), 32'd1);
        check("stale_iresp", 32'(n_iresp - i0), 32'd1);

        // reset while a load is outstanding
        mem_lat = 20;
        dmem_addr = 32'h0000_6000; dmem_rmask = 4'hF;
        repeat (3) @(negedge clk);
        check("rst_mid_busy", 32'(mem_read), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_read", 32'(mem_read), 32'd0);
        check("rst_mid_outs", 32'(|{mem_addr, mem_write, mem_wmask, mem_wdata,
                                     imem_rdata, imem_resp, dmem_rdata, dmem_resp}), 32'd0);
        dmem_rmask = 4'h0;
        d_rdata_exp = '0;
        d0 = n_dresp;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_no_dresp", 32'(n_dresp - d0), 32'd0);
        mem_lat = 2;
        exp_i(32'h0000_0400);
        imem_addr = 32'h0000_0400; imem_rmask = 4'hF;
        wait_resp(1'b0);
        imem_rmask = 4'h0;
        repeat (3) @(negedge clk);

        check("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
        check("mem_queue_empty", 32'(exp_mem.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
